ms_fifo_rr_drain: RTL and testbench

Downstream consumer of the multi-stream tagged FIFO. Each cycle it selects one non-empty flux using round-robin arbitration with a bounded burst. It pops that flux with a one-hot read, strips the tag from the popped word and presents data plus tag on a registered valid/ready output. This stage serialises the per-flux FIFO queues into a single tagged stream for the next dataflow actor.

---
 rtl/ms_fifo_rr_drain_if.sv | 26 ++
 rtl/ms_fifo_rr_drain.sv | 125 ++++++++++++
 tb/tb_ms_fifo_rr_drain.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ms_fifo_rr_drain_if.sv
// Read-port and tagged output stream bundle for ms_fifo_rr_drain.
// master = drain block, slave = FIFO read port plus downstream consumer.
interface ms_fifo_rr_drain_if #(
   parameter int DATA_WIDTH = 8,
   parameter int FLUX       = 2
);
   localparam int TAG_WIDTH = $clog2(FLUX);

   logic [FLUX-1:0]                 empty;
   logic [FLUX-1:0]                 read;
   logic [DATA_WIDTH+TAG_WIDTH-1:0] dout;
   logic [DATA_WIDTH-1:0]           out_data;
   logic [TAG_WIDTH-1:0]            out_tag;
   logic                            out_valid;
   logic                            out_ready;

   modport master (
      input  empty, dout, out_ready,
      output read, out_data, out_tag, out_valid
   );

   modport slave (
      output empty, dout, out_ready,
      input  read, out_data, out_tag, out_valid
   );
endinterface

// File: rtl/ms_fifo_rr_drain.sv
// Round-robin, burst-bounded drain of a multi-stream tagged FIFO into one tagged stream.
// Optional sticky tag-mismatch check on popped words: MS_DRAIN_TAG_CHECK_EN.
module ms_fifo_rr_drain #(
   parameter int DATA_WIDTH = 8,
   parameter int FLUX       = 2,
   parameter int BURST      = 4
) (
   input  logic                i_clk,
   input  logic                i_rst,
   ms_fifo_rr_drain_if.master  bus
`ifdef MS_DRAIN_TAG_CHECK_EN
   ,
   output logic                o_tag_err
`endif
);

   // state   | meaning
   // S_EMPTY | output register holds no valid word
   // S_FULL  | output register holds a word waiting for out_ready

   localparam int TAG_WIDTH = $clog2(FLUX);
   localparam int CNT_W     = $clog2(BURST + 1);
   localparam logic [CNT_W-1:0]     C_BURST = CNT_W'(BURST);
   localparam logic [TAG_WIDTH-1:0] C_LAST  = TAG_WIDTH'(FLUX - 1);

   typedef enum logic {S_EMPTY, S_FULL} state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [TAG_WIDTH-1:0]   r_cur;
   logic [CNT_W-1:0]       r_cnt;
   logic [DATA_WIDTH-1:0]  r_data;
   logic [TAG_WIDTH-1:0]   r_tag;
   logic [TAG_WIDTH-1:0]   w_grant;
   logic                   w_have;
   logic                   w_cont;
   logic                   w_load;
   logic                   w_pop;
   logic [FLUX-1:0]        w_read;

   assign w_load = (r_state == S_EMPTY) | bus.out_ready;

   // cur is scanned last so a lone non-empty flux always gets a fresh burst
   always_comb begin : grant_sel
      int v_idx;
      w_grant = r_cur;
      w_have  = 1'b0;
      w_cont  = 1'b0;
      v_idx   = 0;
      if (!bus.empty[r_cur] && (r_cnt < C_BURST)) begin
         w_have = 1'b1;
         w_cont = 1'b1;
      end else begin
         for (int k = 1; k <= FLUX; k++) begin
            v_idx = (int'(r_cur) + k) % FLUX;
            if (!w_have && !bus.empty[v_idx]) begin
               w_have  = 1'b1;
               w_grant = TAG_WIDTH'(v_idx);
            end
         end
      end
   end

   assign w_pop = w_load & w_have & ~i_rst;

   always_comb begin
      w_read = '0;
      if (w_pop) w_read[w_grant] = 1'b1;
   end

   assign bus.read = w_read;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_EMPTY;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_EMPTY: if (w_pop)                   w_state_nxt = S_FULL;
         S_FULL:  if (bus.out_ready && !w_pop) w_state_nxt = S_EMPTY;
         default:                              w_state_nxt = S_EMPTY;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cur  <= C_LAST;
         r_cnt  <= '0;
         r_data <= '0;
         r_tag  <= '0;
      end else if (w_pop) begin
         r_data <= bus.dout[DATA_WIDTH-1:0];
         r_tag  <= w_grant;
         if (w_cont) begin
            r_cnt <= r_cnt + 1'b1;
         end else begin
            r_cur <= w_grant;
            r_cnt <= CNT_W'(1);
         end
      end
   end

   assign bus.out_valid = (r_state == S_FULL);
   assign bus.out_data  = r_data;
   assign bus.out_tag   = r_tag;

`ifdef MS_DRAIN_TAG_CHECK_EN
   logic r_tag_err;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_tag_err <= 1'b0;
      else if (w_pop && (bus.dout[DATA_WIDTH +: TAG_WIDTH] != w_grant))
         r_tag_err <= 1'b1;
   end

   assign o_tag_err = r_tag_err;
`else
   logic w_unused_tag;
   assign w_unused_tag = ^bus.dout[DATA_WIDTH +: TAG_WIDTH];
`endif

endmodule

// File: tb/tb_ms_fifo_rr_drain.sv
// Bench for ms_fifo_rr_drain: queue-level FIFO and arbitration model for FLUX=2,
// plus a vector table on a FLUX=3 instance for the modulo wrap.
module tb_ms_fifo_rr_drain;
   localparam int DW    = 8;
   localparam int FX    = 2;
   localparam int BU    = 4;
   localparam int TW    = 1;
   localparam int DEPTH = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ms_fifo_rr_drain_if #(.DATA_WIDTH(DW), .FLUX(FX)) bus ();
   ms_fifo_rr_drain_if #(.DATA_WIDTH(DW), .FLUX(3))  bus3 ();

`ifdef MS_DRAIN_TAG_CHECK_EN
   logic tag_err;
   logic tag_err3;
`endif

   ms_fifo_rr_drain #(.DATA_WIDTH(DW), .FLUX(FX), .BURST(BU)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
`ifdef MS_DRAIN_TAG_CHECK_EN
      ,
      .o_tag_err (tag_err)
`endif
   );

   ms_fifo_rr_drain #(.DATA_WIDTH(DW), .FLUX(3), .BURST(BU)) dut3 (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus3)
`ifdef MS_DRAIN_TAG_CHECK_EN
      ,
      .o_tag_err (tag_err3)
`endif
   );

   // upstream FIFO model: per-flux circular store with free-running pointers
   logic [DW-1:0] mem [FX][DEPTH];
   int wr [FX] = '{0, 0};
   int rd [FX] = '{0, 0};
   bit bad_tag = 1'b0;
   int seq = 1;

   always_comb begin
      bus.empty = '1;
      for (int f = 0; f < FX; f++) bus.empty[f] = (wr[f] == rd[f]);
   end

   always_comb begin
      bus.dout = '0;
      for (int f = 0; f < FX; f++)
         if (bus.read[f]) bus.dout = {(bad_tag ? ~TW'(f) : TW'(f)), mem[f][rd[f] % DEPTH]};
   end

   always @(posedge clk)
      for (int f = 0; f < FX; f++)
         if (bus.read[f]) rd[f] <= rd[f] + 1;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic push(input int f);
      mem[f][wr[f] % DEPTH] = DW'(seq);
      wr[f]++;
      seq++;
   endtask

   // reference model of the arbiter and output register
   int m_cur, m_cnt, m_tag;
   bit m_valid;
   logic [DW-1:0] m_data;
   logic [FX-1:0] s_read;

   task automatic model_reset();
      m_cur = FX - 1; m_cnt = 0; m_valid = 0; m_data = '0; m_tag = 0;
   endtask

   task automatic step(input string nm);
      int g;
      bit have, cont, load;
      logic [FX-1:0] er;
      logic [DW-1:0] nd;
      @(negedge clk);
      load = !m_valid || bus.out_ready;
      have = 0; cont = 0; g = 0;
      if ((wr[m_cur] > rd[m_cur]) && (m_cnt < BU)) begin
         g = m_cur; have = 1; cont = 1;
      end else begin
         for (int k = 1; k <= FX; k++) begin
            int f;
            f = (m_cur + k) % FX;
            if (!have && (wr[f] > rd[f])) begin g = f; have = 1; end
         end
      end
      er = '0;
      if (load && have) er[g] = 1'b1;
      s_read = bus.read;
      chk({nm, " read"}, 32'(bus.read), 32'(er));
      nd = mem[g][rd[g] % DEPTH];
      @(posedge clk); #1;
      if (load) begin
         if (have) begin
            m_valid = 1; m_data = nd; m_tag = g;
            if (cont) m_cnt++;
            else begin m_cur = g; m_cnt = 1; end
         end else begin
            m_valid = 0;
         end
      end
      chk({nm, " out_valid"}, 32'(bus.out_valid), 32'(m_valid));
      chk({nm, " out_data"},  32'(bus.out_data),  32'(m_data));
      chk({nm, " out_tag"},   32'(bus.out_tag),   32'(m_tag));
   endtask

   typedef struct {
      logic [2:0] e;
      logic       r;
      logic [2:0] rd;
      logic       v;
      logic [1:0] t;
   } vec3_t;
   vec3_t vt [8];

   int tags [$];
   int exp_seq [8] = '{0, 0, 0, 0, 1, 1, 0, 0};
   int n_rd, run, run_max;
   logic [DW-1:0] held_d;
   logic [TW-1:0] held_t;

   initial begin
      vt[0] = '{3'b011, 1'b1, 3'b100, 1'b1, 2'd2};
      vt[1] = '{3'b011, 1'b1, 3'b100, 1'b1, 2'd2};
      vt[2] = '{3'b011, 1'b1, 3'b100, 1'b1, 2'd2};
      vt[3] = '{3'b011, 1'b1, 3'b100, 1'b1, 2'd2};
      vt[4] = '{3'b010, 1'b0, 3'b000, 1'b1, 2'd2};
      vt[5] = '{3'b010, 1'b1, 3'b001, 1'b1, 2'd0};
      vt[6] = '{3'b111, 1'b1, 3'b000, 1'b0, 2'd0};
      vt[7] = '{3'b101, 1'b1, 3'b010, 1'b1, 2'd1};

      bus.out_ready  = 1'b1;
      bus3.empty     = '1;
      bus3.dout      = '0;
      bus3.out_ready = 1'b1;
      model_reset();

      // reset state, including read held low with a non-empty flux
      #12;
      chk("rst read idle", 32'(bus.read), 32'd0);
      push(0);
      #1;
      chk("rst read masked", 32'(bus.read), 32'd0);
      chk("rst out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst out_data", 32'(bus.out_data), 32'd0);
      chk("rst out_tag", 32'(bus.out_tag), 32'd0);
`ifdef MS_DRAIN_TAG_CHECK_EN
      chk("rst tag_err", 32'(tag_err), 32'd0);
`endif
      wr[0] = rd[0];
      @(negedge clk);
      rst = 1'b0;

      // FLUX=3 wrap after an exhausted burst on flux 2
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         bus3.empty     = vt[i].e;
         bus3.out_ready = vt[i].r;
         #1;
         chk($sformatf("f3 vec%0d read", i), 32'(bus3.read), 32'(vt[i].rd));
         @(posedge clk); #1;
         chk($sformatf("f3 vec%0d valid", i), 32'(bus3.out_valid), 32'(vt[i].v));
         if (vt[i].v) chk($sformatf("f3 vec%0d tag", i), 32'(bus3.out_tag), 32'(vt[i].t));
      end
      bus3.empty = '1;

      for (int i = 0; i < 5; i++) step("idle");

      // 6 words on flux0, flux1 joins after the first grant
      for (int i = 0; i < 6; i++) push(0);
      step("seq");
      if (bus.out_valid) tags.push_back(int'(bus.out_tag));
      push(1); push(1);
      for (int i = 0; i < 9; i++) begin
         step("seq");
         if (bus.out_valid) tags.push_back(int'(bus.out_tag));
      end
      chk("seq length", 32'(tags.size()), 32'd8);
      for (int i = 0; i < 8 && i < tags.size(); i++)
         chk($sformatf("seq tag%0d", i), 32'(tags[i]), 32'(exp_seq[i]));

      // lone flux keeps popping past BURST with no bubble
      for (int i = 0; i < 10; i++) push(0);
      n_rd = 0; run = 0; run_max = 0;
      for (int i = 0; i < 13; i++) begin
         step("lone");
         if (s_read == 2'b01) begin n_rd++; run++; end
         else run = 0;
         if (run > run_max) run_max = run;
      end
      chk("lone pops", 32'(n_rd), 32'd10);
      chk("lone no bubble", 32'(run_max), 32'd10);

      // stall with both fluxes non-empty
      for (int i = 0; i < 5; i++) begin push(0); push(1); end
      step("pre-stall");
      held_d = bus.out_data;
      held_t = bus.out_tag;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step("stall");
         chk("stall data hold", 32'(bus.out_data), 32'(held_d));
         chk("stall tag hold", 32'(bus.out_tag), 32'(held_t));
      end
      bus.out_ready = 1'b1;
      step("resume");
      chk("resume pop", 32'(s_read != 0), 32'd1);
      for (int i = 0; i < 12; i++) step("drain");

      // random traffic and backpressure
      for (int i = 0; i < 400; i++) begin
         for (int f = 0; f < FX; f++)
            if ((wr[f] - rd[f] < 40) && ($urandom_range(99) < 35)) push(f);
         bus.out_ready = ($urandom_range(3) != 0);
         step("rand");
      end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 90; i++) step("rand drain");
      chk("rand drained", 32'(wr[0] - rd[0] + wr[1] - rd[1]), 32'd0);
`ifdef MS_DRAIN_TAG_CHECK_EN
      chk("tag_err clean", 32'(tag_err), 32'd0);
`endif

      // wrong tag on a flux0 pop
      push(0);
      bad_tag = 1'b1;
      step("badtag");
      bad_tag = 1'b0;
`ifdef MS_DRAIN_TAG_CHECK_EN
      chk("tag_err set", 32'(tag_err), 32'd1);
      step("badtag after");
      step("badtag after");
      chk("tag_err sticky", 32'(tag_err), 32'd1);
`else
      chk("badtag fwd tag", 32'(bus.out_tag), 32'd0);
      step("badtag after");
`endif

      // reset asserted mid-operation
      for (int i = 0; i < 5; i++) begin push(0); push(1); end
      step("pre-rst");
      step("pre-rst");
      #2;
      rst = 1'b1;
      #1;
      chk("midrst read", 32'(bus.read), 32'd0);
      chk("midrst out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst out_data", 32'(bus.out_data), 32'd0);
      chk("midrst out_tag", 32'(bus.out_tag), 32'd0);
`ifdef MS_DRAIN_TAG_CHECK_EN
      chk("midrst tag_err", 32'(tag_err), 32'd0);
`endif
      for (int f = 0; f < FX; f++) wr[f] = rd[f];
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      push(0); push(1); push(1);
      for (int i = 0; i < 5; i++) step("post-rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
